mem_arbiter: RTL
================

# mem_arbiter

Sequencing arbiter that shares one single-port 4K x 32 memory between three requesters: the AXI-Lite slave write path, the AXI-Lite slave read path, and the peripheral port. It replaces free-running direct memory access with granted, one-at-a-time transactions. Requesters are served round-robin, and each grant is acknowledged with a one-cycle done pulse. It sits between the AXI-Lite slave FSMs or peripheral and the memory array, which has a combinational read and a synchronous write.

## Interface
- ADDR_W, 12, memory word-address width (depth = 2^ADDR_W)
- DATA_W, 32, data width

- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- aw_req_i  in  1  AXI write request; held until aw_done_o
- aw_addr_i  in  32  AXI write word address
- aw_data_i  in  DATA_W  AXI write data
- aw_done_o  out  1  one-cycle pulse: write committed
- ar_req_i  in  1  AXI read request; held until ar_done_o
- ar_addr_i  in  32  AXI read word address
- ar_data_o  out  DATA_W  AXI read data; valid from ar_done_o, held until next AXI read completes
- ar_done_o  out  1  one-cycle pulse: ar_data_o updated
- p_op_i  in  2  peripheral op: 00 idle, 01 read, 10 write, 11 reserved (treated as idle); held until p_done_o
- p_addr_i  in  32  peripheral word address
- p_w_data_i  in  DATA_W  peripheral write data
- p_r_data_o  out  DATA_W  peripheral read data; held until next peripheral read completes
- p_done_o  out  1  one-cycle pulse: peripheral op complete
- mem_addr_o  out  ADDR_W  memory address
- mem_w_data_o  out  DATA_W  memory write data
- mem_we_o  out  1  memory write enable
- mem_r_data_i  in  DATA_W  combinational memory read data

## Operation
- Requester IDs: 0 = AXI write, 1 = AXI read, 2 = peripheral.
- The FSM has three states: IDLE, ACCESS and DONE.
  - **IDLE:** if any request is active, pick a winner round-robin starting at ptr. Latch the winner's ID, address [ADDR_W-1:0], write data and read/write flag. Set ptr = (winner+1) mod 3. Go to ACCESS. With no request, stay in IDLE.
  - **ACCESS:** drive mem_addr_o and mem_w_data_o from the latched values.
    - For a write, mem_we_o = 1.
    - For a read, capture mem_r_data_i at the end of the cycle into the winner's read-data register.
    - Go to DONE.
  - **DONE:** pulse the winner's done output. Go to IDLE. Requests are not sampled in DONE.
- Address rule: upper address bits are discarded, so there is no range error. For example, address 0x1005 maps to word 0x005.
- If a request drops mid-transaction, the transaction still completes and done still pulses.
- Simultaneous requests are resolved by ptr only. There is no fixed priority.
- mem_we_o is gated by !rst_i. Reset asserted during a write ACCESS cycle therefore suppresses the write.

## Timing
- Reset values:
  - State IDLE, ptr = 0.
  - aw_done_o, ar_done_o, p_done_o, mem_we_o = 0.
  - mem_addr_o, mem_w_data_o = 0.
  - ar_data_o, p_r_data_o = 0.
- Edge numbering:
  - A request is sampled at edge N.
  - ACCESS occupies cycle N+1. The memory write occurs at edge N+2, and read data is registered at edge N+2.
  - Done is high during cycle N+2.
- Throughput: one transaction per 3 cycles.
- Requester handshake: deassert the request in the cycle after done, or keep it high to issue a new transaction. A request still high at the first IDLE after DONE counts as a new request.
- Done pulses and data outputs are registered, so no output depends combinationally on an input. The exception is mem_we_o, which is gated by rst_i.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE/ACCESS/DONE)
  - requester ID constants (REQ_AW=0, REQ_AR=1, REQ_P=2)
  - peripheral op codes (OP_IDLE=00, OP_RD=01, OP_WR=10)
- Sub-module rr_arbiter3 is purely combinational.
  - Inputs: req[2:0] and ptr.
  - Outputs: grant ID and valid.

## Test plan
- **Reset mid-write:** assert rst_i during the ACCESS cycle of an aw write of 0x55 to address 9 → mem_we_o stays 0, address 9 is unchanged, FSM is in IDLE after the edge, and all outputs return to their reset values.
- **Single AXI write then read:**
  - aw 0x0A = 0xDEADBEEF → aw_done_o pulses 2 cycles after the request edge.
  - Then ar 0x0A → ar_data_o = 0xDEADBEEF while ar_done_o is high.
- **Three simultaneous requests after reset:** aw, ar and p_op = 01 all held → done order is AW, AR, P, with done pulses 3 cycles apart. ptr then returns to 0.
- **Address wrap:** peripheral write 0x1234 to address 0x0000_1005 → an AXI read of 0x005 returns 0x1234.
- **p_op_i = 11:** held for 10 cycles with no other request → FSM stays in IDLE, no done pulse, mem_we_o = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-way memory arbiter.
// Requester IDs double as round-robin positions.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_AW = 2'd0;
  localparam req_id_t REQ_AR = 2'd1;
  localparam req_id_t REQ_P  = 2'd2;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;

  function automatic req_id_t rr_next(input req_id_t id);
    return (id >= REQ_P) ? REQ_AW : req_id_t'(id + 2'd1);
  endfunction

  // (base + off) mod 3, base and off both below 4
  function automatic req_id_t rr_idx(input req_id_t base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd6)      return req_id_t'(s - 3'd6);
    else if (s >= 3'd3) return req_id_t'(s - 3'd3);
    else                return s[1:0];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled for port lists.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              aw_req_i;
  logic [31:0]       aw_addr_i;
  logic [DATA_W-1:0] aw_data_i;
  logic              aw_done_o;

  logic              ar_req_i;
  logic [31:0]       ar_addr_i;
  logic [DATA_W-1:0] ar_data_o;
  logic              ar_done_o;

  logic [1:0]        p_op_i;
  logic [31:0]       p_addr_i;
  logic [DATA_W-1:0] p_w_data_i;
  logic [DATA_W-1:0] p_r_data_o;
  logic              p_done_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_w_data_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_r_data_i;

  modport slave (
    input  aw_req_i, aw_addr_i, aw_data_i, output aw_done_o,
    input  ar_req_i, ar_addr_i, output ar_data_o, ar_done_o,
    input  p_op_i, p_addr_i, p_w_data_i, output p_r_data_o, p_done_o,
    output mem_addr_o, mem_w_data_o, mem_we_o, input mem_r_data_i
  );

  modport master (
    output aw_req_i, aw_addr_i, aw_data_i, input aw_done_o,
    output ar_req_i, ar_addr_i, input ar_data_o, ar_done_o,
    output p_op_i, p_addr_i, p_w_data_i, input p_r_data_o, p_done_o,
    input  mem_addr_o, mem_w_data_o, mem_we_o, output mem_r_data_i
  );
endinterface

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin pick: first active request at or after ptr.
module rr_arbiter3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  req_id_t    ptr,
  output req_id_t    grant,
  output logic       valid
);
  req_id_t cand;

  always_comb begin
    grant = REQ_AW;
    valid = 1'b0;
    cand  = REQ_AW;
    for (int i = 0; i < 3; i++) begin
      cand = rr_idx(ptr, 2'(i));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises AXI write, AXI read and peripheral accesses onto one single-port
// memory: IDLE picks a winner, ACCESS drives the memory, DONE pulses the ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_arbiter_if.slave bus
);
  state_t            state, state_n;
  req_id_t           ptr, win, gnt;
  logic              gnt_vld;
  logic [2:0]        req;
  logic              wr, we_q;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, sel_data;
  logic              sel_wr;
  logic [DATA_W-1:0] ar_data_q, p_rdata_q;
  logic              aw_done_q, ar_done_q, p_done_q;
  logic              unused_addr_bits;

  // Reserved op 11 never raises a request
  assign req = {(bus.p_op_i == OP_RD) || (bus.p_op_i == OP_WR),
                bus.ar_req_i, bus.aw_req_i};

  rr_arbiter3 u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (gnt),
    .valid (gnt_vld)
  );

  always_comb begin
    sel_addr = bus.aw_addr_i[ADDR_W-1:0];
    sel_data = bus.aw_data_i;
    sel_wr   = 1'b1;
    case (gnt)
      REQ_AR: begin
        sel_addr = bus.ar_addr_i[ADDR_W-1:0];
        sel_data = '0;
        sel_wr   = 1'b0;
      end
      REQ_P: begin
        sel_addr = bus.p_addr_i[ADDR_W-1:0];
        sel_data = bus.p_w_data_i;
        sel_wr   = (bus.p_op_i == OP_WR);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gnt_vld) state_n = ACCESS;
      ACCESS:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= REQ_AW;
      win       <= REQ_AW;
      wr        <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ar_data_q <= '0;
      p_rdata_q <= '0;
      aw_done_q <= 1'b0;
      ar_done_q <= 1'b0;
      p_done_q  <= 1'b0;
    end else begin
      state     <= state_n;
      we_q      <= 1'b0;
      aw_done_q <= 1'b0;
      ar_done_q <= 1'b0;
      p_done_q  <= 1'b0;
      case (state)
        IDLE: if (gnt_vld) begin
          win     <= gnt;
          ptr     <= rr_next(gnt);
          addr_q  <= sel_addr;
          wdata_q <= sel_data;
          wr      <= sel_wr;
          we_q    <= sel_wr;
        end
        ACCESS: begin
          if (!wr && win == REQ_AR) ar_data_q <= bus.mem_r_data_i;
          if (!wr && win == REQ_P)  p_rdata_q <= bus.mem_r_data_i;
          aw_done_q <= (win == REQ_AW);
          ar_done_q <= (win == REQ_AR);
          p_done_q  <= (win == REQ_P);
        end
        default: ;
      endcase
    end
  end

  // Reset kills a write already in its ACCESS cycle
  assign bus.mem_we_o     = we_q & ~rst_i;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_w_data_o = wdata_q;
  assign bus.ar_data_o    = ar_data_q;
  assign bus.p_r_data_o   = p_rdata_q;
  assign bus.aw_done_o    = aw_done_q;
  assign bus.ar_done_o    = ar_done_q;
  assign bus.p_done_o     = p_done_q;

  assign unused_addr_bits = ^{bus.aw_addr_i[31:ADDR_W], bus.ar_addr_i[31:ADDR_W],
                              bus.p_addr_i[31:ADDR_W]};
endmodule
